axi_vdma_wr_burst_sched: RTL and testbench

- Sequences one video frame into AXI write bursts for the write state core: per line, per burst, it issues write_req/req_addr/req_len.
- Gates each burst on upstream FIFO fill and rotates across FB_NUM frame buffers.
- Sits between the VDMA frame/config logic and the AXI write state core, one instance per write channel.

---
 rtl/axi_vdma_wr_burst_sched_if.sv | 24 ++
 rtl/axi_vdma_wr_burst_sched.sv | 212 +++++++++++++++++++++
 tb/tb_axi_vdma_wr_burst_sched.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_vdma_wr_burst_sched_if.sv
// rtl/axi_vdma_wr_burst_sched_if.sv - burst request handshake between scheduler and AXI write core
interface axi_vdma_wr_burst_sched_if #(
   parameter int ASIZE = 32,
   parameter int LSIZE = 10
);
   logic             write_req;
   logic [LSIZE-1:0] req_len;
   logic [ASIZE-1:0] req_addr;
   logic             req_resp;
   logic             req_done;
   logic             req_err;

   // scheduler side
   modport master (
      output write_req, req_len, req_addr,
      input  req_resp, req_done, req_err
   );

   // write core side
   modport slave (
      input  write_req, req_len, req_addr,
      output req_resp, req_done, req_err
   );
endinterface

// File: rtl/axi_vdma_wr_burst_sched.sv
// rtl/axi_vdma_wr_burst_sched.sv - frame-to-AXI-write-burst scheduler; optional 4 KB split via BURST_4K_SPLIT_EN
module axi_vdma_wr_burst_sched #(
   parameter int ASIZE      = 32,
   parameter int LSIZE      = 10,
   parameter int MAX_BURST  = 256,
   parameter int CSIZE      = 16,
   parameter int FB_NUM     = 3,
   parameter int BEAT_BYTES = 32
) (
   input  logic                    axi_aclk,
   input  logic                    axi_reset,
   input  logic                    enable,
   input  logic                    fs,
   input  logic [FB_NUM*ASIZE-1:0] cfg_base,
   input  logic [CSIZE-1:0]        cfg_line_beats,
   input  logic [CSIZE-1:0]        cfg_lines,
   input  logic [ASIZE-1:0]        cfg_stride,
   input  logic [CSIZE-1:0]        fifo_count,
   axi_vdma_wr_burst_sched_if.master wr_bus,
   output logic                    busy,
   output logic                    frame_done,
   output logic                    frame_err,
   output logic                    fs_skip,
   output logic [1:0]              cur_fb
);
   localparam logic [CSIZE-1:0] MAX_C = CSIZE'(MAX_BURST);

   typedef enum logic [2:0] {
      IDLE, LINE_START, WAIT_FIFO, REQ, WAIT_DONE, NEXT, FRAME_END
   } state_t;

   state_t           state_q, state_d;
   logic [CSIZE-1:0] line_beats_q, line_beats_d;
   logic [CSIZE-1:0] lines_q, lines_d;
   logic [ASIZE-1:0] stride_q, stride_d;
   logic [ASIZE-1:0] line_addr_q, line_addr_d;
   logic [ASIZE-1:0] burst_addr_q, burst_addr_d;
   logic [CSIZE-1:0] line_cnt_q, line_cnt_d;
   logic [CSIZE-1:0] rem_q, rem_d;
   logic [CSIZE-1:0] blen_q, blen_d;
   logic [1:0]       cur_fb_q, cur_fb_d;
   logic             write_req_q, write_req_d;
   logic [LSIZE-1:0] req_len_q, req_len_d;
   logic [ASIZE-1:0] req_addr_q, req_addr_d;
   logic             frame_done_q, frame_done_d;
   logic             frame_err_q, frame_err_d;
   logic             fs_skip_q, fs_skip_d;

   logic [CSIZE-1:0] rem_next;
   logic [ASIZE-1:0] addr_next;
   logic [CSIZE-1:0] line_cnt_next;
   logic [CSIZE-1:0] blen_line;
   logic [CSIZE-1:0] blen_next;
   logic [1:0]       fb_next;

   assign rem_next      = rem_q - blen_q;
   assign addr_next     = burst_addr_q + ASIZE'(blen_q) * ASIZE'(BEAT_BYTES);
   assign line_cnt_next = line_cnt_q + 1'b1;
   assign fb_next       = (cur_fb_q == 2'(FB_NUM - 1)) ? 2'd0 : cur_fb_q + 2'd1;

   // burst length for a fresh line and for the continuation of the current line
   always_comb begin
      blen_line = (line_beats_q > MAX_C) ? MAX_C : line_beats_q;
      blen_next = (rem_next > MAX_C) ? MAX_C : rem_next;
`ifdef BURST_4K_SPLIT_EN
      if (CSIZE'(13'h1000 - {1'b0, line_addr_q[11:0]}) / CSIZE'(BEAT_BYTES) < blen_line)
         blen_line = CSIZE'(13'h1000 - {1'b0, line_addr_q[11:0]}) / CSIZE'(BEAT_BYTES);
      if (CSIZE'(13'h1000 - {1'b0, addr_next[11:0]}) / CSIZE'(BEAT_BYTES) < blen_next)
         blen_next = CSIZE'(13'h1000 - {1'b0, addr_next[11:0]}) / CSIZE'(BEAT_BYTES);
`endif
   end

   // next-state and registered-output logic of the frame sequencer
   always_comb begin
      state_d      = state_q;
      line_beats_d = line_beats_q;
      lines_d      = lines_q;
      stride_d     = stride_q;
      line_addr_d  = line_addr_q;
      burst_addr_d = burst_addr_q;
      line_cnt_d   = line_cnt_q;
      rem_d        = rem_q;
      blen_d       = blen_q;
      cur_fb_d     = cur_fb_q;
      req_len_d    = req_len_q;
      req_addr_d   = req_addr_q;
      frame_err_d  = 1'b0;
      fs_skip_d    = fs && (state_q != IDLE);

      case (state_q)
         IDLE: begin
            if (fs && enable) begin
               line_beats_d = cfg_line_beats;
               lines_d      = cfg_lines;
               stride_d     = cfg_stride;
               line_addr_d  = cfg_base[cur_fb_q*ASIZE +: ASIZE];
               line_cnt_d   = '0;
               state_d      = (cfg_lines == '0 || cfg_line_beats == '0) ? FRAME_END : LINE_START;
            end
         end
         LINE_START: begin
            if (!enable) begin
               frame_err_d = 1'b1;
               state_d     = IDLE;
            end else begin
               rem_d        = line_beats_q;
               burst_addr_d = line_addr_q;
               blen_d       = blen_line;
               state_d      = WAIT_FIFO;
            end
         end
         WAIT_FIFO: begin
            if (!enable) begin
               frame_err_d = 1'b1;
               state_d     = IDLE;
            end else if (fifo_count >= blen_q) begin
               state_d = REQ;
            end
         end
         REQ: begin
            // an issued request must be accepted before anything else happens
            if (wr_bus.req_resp) state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (wr_bus.req_err) begin
               frame_err_d = 1'b1;
               state_d     = IDLE;
            end else if (wr_bus.req_done) begin
               state_d = NEXT;
            end
         end
         NEXT: begin
            if (!enable) begin
               frame_err_d = 1'b1;
               state_d     = IDLE;
            end else begin
               rem_d        = rem_next;
               burst_addr_d = addr_next;
               if (rem_next != '0) begin
                  blen_d  = blen_next;
                  state_d = WAIT_FIFO;
               end else begin
                  line_cnt_d  = line_cnt_next;
                  line_addr_d = line_addr_q + stride_q;
                  state_d     = (line_cnt_next == lines_q) ? FRAME_END : LINE_START;
               end
            end
         end
         FRAME_END: begin
            cur_fb_d = fb_next;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase

      frame_done_d = (state_d == FRAME_END);
      write_req_d  = (state_d == REQ);
      // capture the request fields once on entry so they stay stable while write_req is high
      if (state_d == REQ && state_q != REQ) begin
         req_addr_d = burst_addr_q;
         req_len_d  = LSIZE'(blen_q - 1'b1);
      end
   end

   // state and datapath registers
   always_ff @(posedge axi_aclk or posedge axi_reset) begin
      if (axi_reset) begin
         state_q      <= IDLE;
         line_beats_q <= '0;
         lines_q      <= '0;
         stride_q     <= '0;
         line_addr_q  <= '0;
         burst_addr_q <= '0;
         line_cnt_q   <= '0;
         rem_q        <= '0;
         blen_q       <= '0;
         cur_fb_q     <= '0;
         write_req_q  <= 1'b0;
         req_len_q    <= '0;
         req_addr_q   <= '0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
         fs_skip_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         line_beats_q <= line_beats_d;
         lines_q      <= lines_d;
         stride_q     <= stride_d;
         line_addr_q  <= line_addr_d;
         burst_addr_q <= burst_addr_d;
         line_cnt_q   <= line_cnt_d;
         rem_q        <= rem_d;
         blen_q       <= blen_d;
         cur_fb_q     <= cur_fb_d;
         write_req_q  <= write_req_d;
         req_len_q    <= req_len_d;
         req_addr_q   <= req_addr_d;
         frame_done_q <= frame_done_d;
         frame_err_q  <= frame_err_d;
         fs_skip_q    <= fs_skip_d;
      end
   end

   assign wr_bus.write_req = write_req_q;
   assign wr_bus.req_len   = req_len_q;
   assign wr_bus.req_addr  = req_addr_q;
   assign busy             = (state_q != IDLE);
   assign frame_done       = frame_done_q;
   assign frame_err        = frame_err_q;
   assign fs_skip          = fs_skip_q;
   assign cur_fb           = cur_fb_q;
endmodule

// File: tb/tb_axi_vdma_wr_burst_sched.sv
// tb/tb_axi_vdma_wr_burst_sched.sv - directed self-checking bench for axi_vdma_wr_burst_sched
module tb_axi_vdma_wr_burst_sched;
   logic        clk;
   logic        rst;
   logic        enable;
   logic        fs;
   logic [95:0] cfg_base;
   logic [15:0] cfg_line_beats;
   logic [15:0] cfg_lines;
   logic [31:0] cfg_stride;
   logic [15:0] fifo_count;
   logic        busy, frame_done, frame_err, fs_skip;
   logic [1:0]  cur_fb;

   axi_vdma_wr_burst_sched_if #(.ASIZE(32), .LSIZE(10)) bus ();

   axi_vdma_wr_burst_sched dut (
      .axi_aclk       (clk),
      .axi_reset      (rst),
      .enable         (enable),
      .fs             (fs),
      .cfg_base       (cfg_base),
      .cfg_line_beats (cfg_line_beats),
      .cfg_lines      (cfg_lines),
      .cfg_stride     (cfg_stride),
      .fifo_count     (fifo_count),
      .wr_bus         (bus),
      .busy           (busy),
      .frame_done     (frame_done),
      .frame_err      (frame_err),
      .fs_skip        (fs_skip),
      .cur_fb         (cur_fb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_err    = 0;
   int          burst_cnt = 0;
   int          err_at    = 0;
   logic [31:0] log_addr [0:15];
   logic [9:0]  log_len  [0:15];
   logic        got_done, got_err;
   int          wait_cycles;
   logic        saw_req;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // write core model: accepts 2 cycles after write_req, completes one cycle later
   initial begin
      bus.req_resp = 1'b0;
      bus.req_done = 1'b0;
      bus.req_err  = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.write_req) begin
            if (burst_cnt < 16) begin
               log_addr[burst_cnt] = bus.req_addr;
               log_len[burst_cnt]  = bus.req_len;
            end
            burst_cnt++;
            @(negedge clk);
            bus.req_resp = 1'b1;
            @(negedge clk);
            bus.req_resp = 1'b0;
            @(negedge clk);
            if (burst_cnt == err_at) bus.req_err = 1'b1;
            else                     bus.req_done = 1'b1;
            @(negedge clk);
            bus.req_err  = 1'b0;
            bus.req_done = 1'b0;
         end
      end
   end

   task automatic start_frame();
      burst_cnt = 0;
      @(negedge clk);
      fs = 1'b1;
      @(negedge clk);
      fs = 1'b0;
   endtask

   task automatic wait_end(input string tag);
      got_done    = 1'b0;
      got_err     = 1'b0;
      wait_cycles = 0;
      for (int i = 0; i < 3000; i++) begin
         if (frame_done) begin got_done = 1'b1; break; end
         if (frame_err)  begin got_err  = 1'b1; break; end
         wait_cycles++;
         @(negedge clk);
      end
      if (!got_done && !got_err) check({tag, "_timeout"}, 0, 1);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; enable = 1'b1; fs = 1'b0;
      cfg_base = {32'h0, 32'h0, 32'h1000_0000};
      cfg_line_beats = 16'd300; cfg_lines = 16'd2; cfg_stride = 32'h2000;
      fifo_count = 16'd1000;
      idle_cycles(3);
      check("rst_write_req", bus.write_req, 0);
      check("rst_busy", busy, 0);
      check("rst_cur_fb", cur_fb, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_req_addr", bus.req_addr, 0);
      rst = 1'b0;
      idle_cycles(2);

      // two lines of 300 beats split at MAX_BURST
      start_frame();
      wait_end("t1");
      check("t1_done", got_done, 1);
      check("t1_nbursts", burst_cnt, 4);
      check("t1_a0", log_addr[0], 32'h1000_0000); check("t1_l0", log_len[0], 255);
      check("t1_a1", log_addr[1], 32'h1000_2000); check("t1_l1", log_len[1], 43);
      check("t1_a2", log_addr[2], 32'h1000_2000); check("t1_l2", log_len[2], 255);
      check("t1_a3", log_addr[3], 32'h1000_4000); check("t1_l3", log_len[3], 43);
      idle_cycles(1);
      check("t1_cur_fb", cur_fb, 1);

      // fifo gating
      cfg_base = {32'h0, 32'h0050_0000, 32'h0};
      cfg_line_beats = 16'd200; cfg_lines = 16'd1; fifo_count = 16'd100;
      start_frame();
      saw_req = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.write_req) saw_req = 1'b1;
         @(negedge clk);
      end
      check("t2_no_req_low_fifo", saw_req, 0);
      check("t2_busy", busy, 1);
      fifo_count = 16'd200;
      wait_end("t2");
      check("t2_done", got_done, 1);
      check("t2_nbursts", burst_cnt, 1);
      check("t2_len", log_len[0], 199);
      check("t2_addr", log_addr[0], 32'h0050_0000);
      fifo_count = 16'd1000;

      // reset returns cur_fb to 0, then buffer rotation
      @(negedge clk); rst = 1'b1;
      idle_cycles(2);
      check("t3_rst_cur_fb", cur_fb, 0);
      rst = 1'b0;
      cfg_base = {32'h0020_0000, 32'h0010_0000, 32'h0000_0000};
      cfg_line_beats = 16'd16; cfg_lines = 16'd1;
      for (int f = 0; f < 4; f++) begin
         check($sformatf("t3_fb%0d", f), cur_fb, f % 3);
         start_frame();
         wait_end("t3");
         check($sformatf("t3_addr%0d", f), log_addr[0], (f % 3) * 32'h0010_0000);
         check($sformatf("t3_done%0d", f), got_done, 1);
         idle_cycles(1);
      end

      // error on second burst
      cfg_line_beats = 16'd300; err_at = 2;
      start_frame();
      wait_end("t4");
      check("t4_err", got_err, 1);
      check("t4_no_done", got_done, 0);
      idle_cycles(20);
      check("t4_nbursts", burst_cnt, 2);
      check("t4_cur_fb", cur_fb, 1);
      err_at = 0;
      start_frame();
      wait_end("t4r");
      check("t4r_done", got_done, 1);
      check("t4r_addr", log_addr[0], 32'h0010_0000);
      idle_cycles(1);
      check("t4r_cur_fb", cur_fb, 2);

      // fs while busy
      start_frame();
      idle_cycles(3);
      fs = 1'b1;
      @(negedge clk);
      fs = 1'b0;
      check("t5_fs_skip", fs_skip, 1);
      wait_end("t5");
      check("t5_done", got_done, 1);
      check("t5_nbursts", burst_cnt, 2);
      check("t5_addr", log_addr[0], 32'h0020_0000);
      idle_cycles(1);
      check("t5_cur_fb", cur_fb, 0);

      // zero lines completes without bursts
      cfg_lines = 16'd0;
      start_frame();
      wait_end("t6");
      check("t6_done", got_done, 1);
      check("t6_fast", wait_cycles <= 2, 1);
      check("t6_nbursts", burst_cnt, 0);
      idle_cycles(1);
      check("t6_cur_fb", cur_fb, 1);

      // enable dropped during a burst
      cfg_lines = 16'd1; cfg_line_beats = 16'd300;
      start_frame();
      for (int i = 0; i < 200 && burst_cnt < 1; i++) @(negedge clk);
      enable = 1'b0;
      wait_end("t7");
      check("t7_err", got_err, 1);
      idle_cycles(10);
      check("t7_nbursts", burst_cnt, 1);
      check("t7_cur_fb", cur_fb, 1);
      enable = 1'b1;

      // 4 KB boundary handling
      cfg_base = {32'h0F80, 32'h0F80, 32'h0F80};
      cfg_line_beats = 16'd64;
      start_frame();
      wait_end("t8");
      check("t8_done", got_done, 1);
      check("t8_a0", log_addr[0], 32'h0F80);
`ifdef BURST_4K_SPLIT_EN
      check("t8_nbursts", burst_cnt, 2);
      check("t8_l0", log_len[0], 3);
      check("t8_a1", log_addr[1], 32'h1000);
      check("t8_l1", log_len[1], 59);
`else
      check("t8_nbursts", burst_cnt, 1);
      check("t8_l0", log_len[0], 63);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
